// File: rtl/mul4_pkg.sv
// Shared constants and FSM state type for the 2x2 multiplier fitness scorer.
package mul4_pkg;

  localparam int unsigned LANES   = 16;
  localparam int unsigned SCORE_W = 16;
  localparam int unsigned CNT_W   = 10;
  // Width holding a popcount of 0..4*LANES
  localparam int unsigned PCNT_W  = $clog2(4 * LANES + 1);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : mul4_pkg

// File: rtl/mul4_golden.sv
// Bit-sliced golden 2x2 unsigned product; one lane per bit position.
module mul4_golden #(
  parameter int unsigned LANES = 16
) (
  input  logic [LANES-1:0] a1,
  input  logic [LANES-1:0] a0,
  input  logic [LANES-1:0] b1,
  input  logic [LANES-1:0] b0,
  output logic [LANES-1:0] p3_c,
  output logic [LANES-1:0] p2_c,
  output logic [LANES-1:0] p1_c,
  output logic [LANES-1:0] p0_c
);

  // Partial products of {a1,a0} * {b1,b0}, carries resolved bitwise per lane
  always_comb begin
    p0_c = a0 & b0;
    p1_c = (a1 & b0) ^ (a0 & b1);
    p2_c = (a1 & b1) ^ (a1 & b0 & a0 & b1);
    p3_c = a1 & b1 & a0 & b0;
  end

endmodule : mul4_golden

// File: rtl/mul4_fitness_scorer.sv
// Scores candidate 2x2 multiplier outputs against the golden product over
// NUM_WORDS bit-sliced words: match/popcount pipeline, then a held result.
module mul4_fitness_scorer
  import mul4_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 4,
  parameter int unsigned LANES     = mul4_pkg::LANES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] a1,
  input  logic [LANES-1:0] a0,
  input  logic [LANES-1:0] b1,
  input  logic [LANES-1:0] b0,
  input  logic [LANES-1:0] y3,
  input  logic [LANES-1:0] y2,
  input  logic [LANES-1:0] y1,
  input  logic [LANES-1:0] y0,
  output logic [15:0]      score,
  output logic             perfect,
  output logic             score_valid,
  input  logic             score_ready
);

  localparam int unsigned MATCH_W = 4 * LANES;
  localparam int unsigned POP_W   = $clog2(MATCH_W + 1);
  localparam logic [SCORE_W-1:0] PERFECT_SCORE = SCORE_W'(4 * LANES * NUM_WORDS);
  localparam logic [CNT_W-1:0]   LAST_WORD     = CNT_W'(NUM_WORDS - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 drain_q, drain_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [SCORE_W-1:0]   accum_q, accum_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 perfect_q, perfect_d;
  logic                 score_valid_q, score_valid_d;
  logic                 in_ready_q, in_ready_d;

  logic [LANES-1:0]     p3_c, p2_c, p1_c, p0_c;
  logic [MATCH_W-1:0]   match_c;
  logic [POP_W-1:0]     pcnt_c;
  logic                 accept_c;
  logic                 handshake_c;

  mul4_golden #(
    .LANES (LANES)
  ) u_golden (
    .a1   (a1),
    .a0   (a0),
    .b1   (b1),
    .b0   (b0),
    .p3_c (p3_c),
    .p2_c (p2_c),
    .p1_c (p1_c),
    .p0_c (p0_c)
  );

  // Per-bit correctness of the candidate against the golden product
  always_comb begin
    match_c = {~(y3 ^ p3_c), ~(y2 ^ p2_c), ~(y1 ^ p1_c), ~(y0 ^ p0_c)};
  end

  // Popcount of the registered match vector (stage 2 operand)
  always_comb begin
    pcnt_c = '0;
    for (int i = 0; i < int'(MATCH_W); i++) begin
      pcnt_c = pcnt_c + POP_W'(match_q[i]);
    end
  end

  // Next-state, pipeline and output logic; clr overrides everything
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    drain_d       = drain_q;
    match_d       = match_q;
    s1_valid_d    = 1'b0;
    accum_d       = accum_q;
    score_d       = score_q;
    perfect_d     = perfect_q;
    score_valid_d = score_valid_q;

    accept_c    = in_valid && (state_q == ST_ACCUM);
    handshake_c = score_valid_q && score_ready;

    if (s1_valid_q) begin
      accum_d = accum_q + SCORE_W'(pcnt_c);
    end

    unique case (state_q)
      ST_ACCUM: begin
        if (accept_c) begin
          s1_valid_d = 1'b1;
          match_d    = match_c;
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            drain_d = 1'b0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Two cycles: lets the final word's popcount land in the accumulator
        if (drain_q) begin
          drain_d = 1'b0;
          state_d = ST_DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (!score_valid_q) begin
          score_valid_d = 1'b1;
          score_d       = accum_q;
          perfect_d     = (accum_q == PERFECT_SCORE);
        end else if (handshake_c) begin
          score_valid_d = 1'b0;
          score_d       = '0;
          perfect_d     = 1'b0;
          accum_d       = '0;
          state_d       = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase

    if (clr) begin
      state_d       = ST_ACCUM;
      cnt_d         = '0;
      drain_d       = 1'b0;
      s1_valid_d    = 1'b0;
      accum_d       = '0;
      score_d       = '0;
      perfect_d     = 1'b0;
      score_valid_d = 1'b0;
    end

    in_ready_d = (state_d == ST_ACCUM);
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_ACCUM;
      cnt_q         <= '0;
      drain_q       <= 1'b0;
      match_q       <= '0;
      s1_valid_q    <= 1'b0;
      accum_q       <= '0;
      score_q       <= '0;
      perfect_q     <= 1'b0;
      score_valid_q <= 1'b0;
      in_ready_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      drain_q       <= drain_d;
      match_q       <= match_d;
      s1_valid_q    <= s1_valid_d;
      accum_q       <= accum_d;
      score_q       <= score_d;
      perfect_q     <= perfect_d;
      score_valid_q <= score_valid_d;
      in_ready_q    <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign score       = score_q;
  assign perfect     = perfect_q;
  assign score_valid = score_valid_q;

endmodule : mul4_fitness_scorer

// File: tb/tb_mul4_fitness_scorer.sv
// Directed bench for mul4_fitness_scorer (NUM_WORDS=4, LANES=16).
module tb_mul4_fitness_scorer;

  localparam logic [15:0] A0 = 16'hAAAA;
  localparam logic [15:0] A1 = 16'hCCCC;
  localparam logic [15:0] B0 = 16'hF0F0;
  localparam logic [15:0] B1 = 16'hFF00;
  localparam logic [15:0] Y0 = 16'hA0A0;
  localparam logic [15:0] Y1 = 16'h6AC0;
  localparam logic [15:0] Y2 = 16'h4C00;
  localparam logic [15:0] Y3 = 16'h8000;
  localparam logic [15:0] Y1_BAD = 16'h953F;

  logic        clk, rst_n, clr, in_valid, in_ready;
  logic [15:0] a1, a0, b1, b0, y3, y2, y1, y0;
  logic [15:0] score;
  logic        perfect, score_valid, score_ready;

  int n_cmp = 0;
  int n_err = 0;

  mul4_fitness_scorer #(
    .NUM_WORDS (4),
    .LANES     (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a1          (a1),
    .a0          (a0),
    .b1          (b1),
    .b0          (b0),
    .y3          (y3),
    .y2          (y2),
    .y1          (y1),
    .y0          (y0),
    .score       (score),
    .perfect     (perfect),
    .score_valid (score_valid),
    .score_ready (score_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one word at a negedge; it is accepted on the following posedge
  task automatic drive_word(input logic [15:0] v0, v1, v2, v3);
    @(negedge clk);
    check("in_ready_accum", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    y0 = v0; y1 = v1; y2 = v2; y3 = v3;
  endtask

  // Four back-to-back words: first uses y1 = first_y1, rest use rest_y1
  task automatic run4(input logic [15:0] v0, first_y1, rest_y1, v2, v3);
    drive_word(v0, first_y1, v2, v3);
    for (int w = 1; w < 4; w++) drive_word(v0, rest_y1, v2, v3);
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_drain", 32'(in_ready), 32'd0);
  endtask

  // Counts negedges from the one after the last accept until score_valid
  task automatic wait_valid(input int exp_lat);
    int lat = 0;
    while (!score_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic take_score();
    score_ready = 1'b1;
    @(negedge clk);
    score_ready = 1'b0;
    check("valid_after_hs", 32'(score_valid), 32'd0);
    check("ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  task automatic expect_score(input int exp_score, input logic exp_perf);
    check("score", 32'(score), 32'(exp_score));
    check("perfect", 32'(perfect), 32'(exp_perf));
    check("score_valid", 32'(score_valid), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; score_ready = 1'b0;
    a0 = A0; a1 = A1; b0 = B0; b1 = B1;
    y0 = '0; y1 = '0; y2 = '0; y3 = '0;
    #1;
    check("rst_score", 32'(score), 32'd0);
    check("rst_perfect", 32'(perfect), 32'd0);
    check("rst_valid", 32'(score_valid), 32'd0);
    #20 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // All-correct run
    run4(Y0, Y1, Y1, Y2, Y3);
    wait_valid(3);
    expect_score(256, 1'b1);
    take_score();

    // All-zero candidate: 14 product ones per word are wrong
    run4(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    wait_valid(3);
    expect_score(200, 1'b0);
    take_score();

    // y1 fully wrong on words 2..4
    run4(Y0, Y1, Y1_BAD, Y2, Y3);
    wait_valid(3);
    expect_score(208, 1'b0);
    take_score();

    // Back-pressure in DONE: input ignored, result held
    run4(Y0, Y1, Y1, Y2, Y3);
    wait_valid(3);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      y0 = 16'h1234;
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_score", 32'(score), 32'd256);
      check("bp_valid", 32'(score_valid), 32'd1);
    end
    in_valid = 1'b0;
    take_score();
    run4(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    wait_valid(3);
    expect_score(200, 1'b0);
    take_score();

    // clr after two accepts, with a colliding word that must not count
    drive_word(16'h0, 16'h0, 16'h0, 16'h0);
    drive_word(16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    check("clr_in_ready", 32'(in_ready), 32'd1);
    check("clr_valid", 32'(score_valid), 32'd0);
    run4(Y0, Y1, Y1, Y2, Y3);
    wait_valid(3);
    expect_score(256, 1'b1);

    // clr in DONE with the handshake offered: clr wins
    score_ready = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    score_ready = 1'b0;
    check("clr_done_valid", 32'(score_valid), 32'd0);
    check("clr_done_score", 32'(score), 32'd0);
    check("clr_done_ready", 32'(in_ready), 32'd1);

    // Reset while a score is held: outputs drop at once
    run4(Y0, Y1, Y1, Y2, Y3);
    wait_valid(3);
    #1 rst_n = 1'b0;
    #1;
    check("arst_score", 32'(score), 32'd0);
    check("arst_perfect", 32'(perfect), 32'd0);
    check("arst_valid", 32'(score_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_in_ready", 32'(in_ready), 32'd1);

    // Reset mid-run: partial words discarded
    drive_word(16'h0, 16'h0, 16'h0, 16'h0);
    drive_word(16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run4(Y0, Y1, Y1, Y2, Y3);
    wait_valid(3);
    expect_score(256, 1'b1);
    take_score();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mul4_fitness_scorer
